// File: rtl/concat_pkg.sv
// Shared types and helpers for the nonce-sweeping concatenator.
// Provides the block-width helper and the two-state controller encoding.
package concat_pkg;

    function automatic int blk_w(input int data_w, input int nonce_w);
        return data_w + nonce_w;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } concat_state_t;

endpackage

// File: rtl/concat_lane.sv
// One lane of an output block: {entry, base + iter}, where the nonce wraps modulo 2^NONCE_W.
module concat_lane
    import concat_pkg::*;
#(
    parameter int DATA_W  = 12,
    parameter int NONCE_W = 4
) (
    input  logic [DATA_W-1:0]                    i_entry_l,
    input  logic [NONCE_W-1:0]                   i_base_l,
    input  logic [NONCE_W-1:0]                   i_iter,
    output logic [blk_w(DATA_W, NONCE_W)-1:0]    o_lane
);

    logic [NONCE_W-1:0] w_nonce;

    assign w_nonce = i_base_l + i_iter;
    assign o_lane  = {i_entry_l, w_nonce};

endmodule

// File: rtl/concatenador_sweep.sv
// Payload concatenator with an internal nonce sweep: each accepted payload yields
// sweep_len+1 registered blocks whose lanes are {entry_l, base_l + iter}.
module concatenador_sweep
    import concat_pkg::*;
#(
    parameter int LANES   = 8,
    parameter int DATA_W  = 12,
    parameter int NONCE_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic                                      selector,
    input  logic [NONCE_W-1:0]                        sweep_len,
    input  logic [LANES*DATA_W-1:0]                   entry,
    input  logic [LANES*NONCE_W-1:0]                  nonce,
    input  logic                                      flush,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [LANES*blk_w(DATA_W, NONCE_W)-1:0]   block_out,
    output logic                                      out_last,
    output logic [CNT_W-1:0]                          drop_cnt
);

    localparam int BLK_W = blk_w(DATA_W, NONCE_W);

    concat_state_t              r_state;
    concat_state_t              w_state_nxt;
    logic [NONCE_W-1:0]         r_iter;
    logic [NONCE_W-1:0]         w_iter_nxt;
    logic [NONCE_W-1:0]         w_iter_inc;
    logic [LANES*DATA_W-1:0]    r_entry;
    logic [LANES*DATA_W-1:0]    w_entry_nxt;
    logic [LANES*NONCE_W-1:0]   r_base;
    logic [LANES*NONCE_W-1:0]   w_base_nxt;
    logic [NONCE_W-1:0]         r_len;
    logic [NONCE_W-1:0]         w_len_nxt;
    logic                       r_valid;
    logic                       w_valid_nxt;
    logic                       r_last;
    logic                       w_last_nxt;
    logic                       w_load_blk;
    logic [LANES*BLK_W-1:0]     r_block;
    logic [LANES*BLK_W-1:0]     w_block_nxt;
    logic [CNT_W-1:0]           r_drop_cnt;
    logic                       w_accept;

    // A new payload can only be taken when the current sweep is finishing this cycle.
    assign in_ready   = reset && !flush &&
                        ((r_state == IDLE) || ((r_state == EMIT) && out_ready && r_last));
    assign w_accept   = in_valid && in_ready;
    assign w_iter_inc = r_iter + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_iter_nxt  = r_iter;
        w_entry_nxt = r_entry;
        w_base_nxt  = r_base;
        w_len_nxt   = r_len;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        w_load_blk  = 1'b0;
        if (flush) begin
            w_state_nxt = IDLE;
            w_iter_nxt  = '0;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
        end else if (w_accept && selector) begin
            w_state_nxt = EMIT;
            w_iter_nxt  = '0;
            w_entry_nxt = entry;
            w_base_nxt  = nonce;
            w_len_nxt   = sweep_len;
            w_valid_nxt = 1'b1;
            w_last_nxt  = (sweep_len == '0);
            w_load_blk  = 1'b1;
        end else if ((r_state == EMIT) && out_ready) begin
            if (r_last) begin
                w_state_nxt = IDLE;
                w_iter_nxt  = '0;
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
            end else begin
                w_iter_nxt  = w_iter_inc;
                w_last_nxt  = (w_iter_inc == r_len);
                w_load_blk  = 1'b1;
            end
        end
    end

    // Lanes are fed the next-cycle hold values so the block register loads in step with the FSM.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        concat_lane #(
            .DATA_W  (DATA_W),
            .NONCE_W (NONCE_W)
        ) u_lane (
            .i_entry_l (w_entry_nxt[l*DATA_W +: DATA_W]),
            .i_base_l  (w_base_nxt[l*NONCE_W +: NONCE_W]),
            .i_iter    (w_iter_nxt),
            .o_lane    (w_block_nxt[l*BLK_W +: BLK_W])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_iter  <= '0;
            r_entry <= '0;
            r_base  <= '0;
            r_len   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_block <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_iter  <= w_iter_nxt;
            r_entry <= w_entry_nxt;
            r_base  <= w_base_nxt;
            r_len   <= w_len_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            if (w_load_blk) begin
                r_block <= w_block_nxt;
            end
        end
    end

    // Discarded payloads are counted; the counter sticks at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop_cnt <= '0;
        end else if (w_accept && !selector && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign out_valid = r_valid;
    assign out_last  = r_last;
    assign block_out = r_block;
    assign drop_cnt  = r_drop_cnt;

endmodule
